// File: rtl/neuron_spike_monitor.sv
// neuron_spike_monitor: rising-threshold spike detector with spike counter and inter-spike-interval FIFO.
// Latency: spike, spike_count and the new ISI entry appear one cycle after the detecting sample.
// Backpressure: i_isi_ready pops the head; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
// Option: define SPIKE_MON_REFRACT_EN to suppress detects for REFRACT enabled cycles after each detect.
module neuron_spike_monitor #(
   parameter int FIFO_DEPTH = 4,
   parameter int ISI_W      = 16,
   parameter int REFRACT    = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ena,
   input  logic [7:0]       i_v_in,
   input  logic [7:0]       i_thresh,
   input  logic             i_clr,
   output logic             o_spike,
   output logic [7:0]       o_spike_count,
   output logic [ISI_W-1:0] o_isi_data,
   output logic             o_isi_valid,
   input  logic             i_isi_ready,
   output logic             o_overflow
);

   localparam int               AW      = $clog2(FIFO_DEPTH);
   localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};
   localparam logic [AW:0]      PTR_ONE = 1;

   // Reject unsupported configurations at elaboration
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REFRACT < 1) begin : g_param_check
      $error("neuron_spike_monitor: FIFO_DEPTH must be a power of two in 2..16 and REFRACT >= 1");
   end

   logic                r_prev_above;
   logic [ISI_W-1:0]    r_isi_cnt;
   logic                r_spike;
   logic [7:0]          r_spike_count;
   logic                r_overflow;
   logic [ISI_W-1:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;

   logic                w_above;
   logic                w_refr_ok;
   logic                w_detect;
   logic [ISI_W-1:0]    w_isi_next;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;

   assign w_above    = $signed(i_v_in) > $signed(i_thresh);
   assign w_detect   = i_ena && w_above && !r_prev_above && w_refr_ok;
   // Saturating increment; also the value pushed on a detect
   assign w_isi_next = (r_isi_cnt == ISI_MAX) ? ISI_MAX : r_isi_cnt + ISI_W'(1);

   // Extra pointer bit distinguishes full from empty when the indices match
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && i_isi_ready;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push
   assign w_push  = w_detect && (!w_full || w_pop);
   assign w_drop  = w_detect && w_full && !w_pop;

`ifdef SPIKE_MON_REFRACT_EN
   localparam int RW = $clog2(REFRACT + 1);
   logic [RW-1:0] r_refract;

   assign w_refr_ok = (r_refract == '0);

   // Lockout counter: loaded on detect, counts down only on enabled cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_refract <= '0;
      end else if (w_detect) begin
         r_refract <= RW'(REFRACT);
      end else if (i_ena && r_refract != '0) begin
         r_refract <= r_refract - RW'(1);
      end
   end
`else
   assign w_refr_ok = 1'b1;
`endif

   // Crossing history and ISI counter advance only on enabled cycles
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev_above <= 1'b0;
         r_isi_cnt    <= '0;
      end else if (i_ena) begin
         r_prev_above <= w_above;
         r_isi_cnt    <= w_detect ? '0 : w_isi_next;
      end
   end

   // Spike pulse, spike counter and sticky overflow; clear yields to a coincident detect/drop
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_spike       <= 1'b0;
         r_spike_count <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_spike <= w_detect;
         if (i_clr) begin
            r_spike_count <= w_detect ? 8'd1 : 8'd0;
            r_overflow    <= w_drop;
         end else begin
            if (w_detect) begin
               r_spike_count <= r_spike_count + 8'd1;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   // FIFO pointers wrap naturally through the extra MSB
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage needs no reset: contents are only observed while valid
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_isi_next;
      end
   end

   assign o_spike       = r_spike;
   assign o_spike_count = r_spike_count;
   assign o_overflow    = r_overflow;
   assign o_isi_valid   = !w_empty;
   assign o_isi_data    = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_neuron_spike_monitor.sv
// Bench for neuron_spike_monitor: directed scenarios plus random stimulus against a queue-based reference model.
module tb_neuron_spike_monitor;

   localparam int DEPTH   = 4;
   localparam int ISI_W   = 16;
   localparam int REFRACT = 3;
   localparam longint ISI_MAX = (longint'(1) << ISI_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             ena = 1'b0;
   logic [7:0]       v_in = 8'h00;
   logic [7:0]       thresh = 8'h10;
   logic             clr = 1'b0;
   logic             isi_ready = 1'b0;
   logic             spike;
   logic [7:0]       spike_count;
   logic [ISI_W-1:0] isi_data;
   logic             isi_valid;
   logic             overflow;

   int n_tests = 0;
   int n_fail  = 0;

   neuron_spike_monitor #(.FIFO_DEPTH(DEPTH), .ISI_W(ISI_W), .REFRACT(REFRACT)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_ena         (ena),
      .i_v_in        (v_in),
      .i_thresh      (thresh),
      .i_clr         (clr),
      .o_spike       (spike),
      .o_spike_count (spike_count),
      .o_isi_data    (isi_data),
      .o_isi_valid   (isi_valid),
      .i_isi_ready   (isi_ready),
      .o_overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spike times indexed by enabled-cycle number, FIFO as a queue
   int     m_q[$];
   int     m_count = 0;
   bit     m_ovf   = 0;
   bit     m_spike = 0;
   bit     m_prev  = 0;
   longint m_ecyc  = 0;
   longint m_last  = -1;
   bit     m_has   = 0;
   bit     m_det, m_drop, m_above;
   longint m_isi;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_count = 0; m_ovf = 0; m_spike = 0; m_prev = 0;
         m_ecyc = 0; m_last = -1; m_has = 0;
      end else begin
         m_det = 0; m_drop = 0; m_isi = 0;
         if (ena) begin
            m_above = $signed(v_in) > $signed(thresh);
            m_det = m_above && !m_prev;
`ifdef SPIKE_MON_REFRACT_EN
            if (m_has && (m_ecyc - m_last) <= REFRACT) m_det = 0;
`endif
            m_prev = m_above;
            if (m_det) begin
               m_isi = m_ecyc - m_last;
               if (m_isi > ISI_MAX) m_isi = ISI_MAX;
               m_last = m_ecyc;
               m_has = 1;
            end
            m_ecyc++;
         end
         if (m_q.size() > 0 && isi_ready) void'(m_q.pop_front());
         if (m_det) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(m_isi));
            else m_drop = 1;
         end
         m_spike = m_det;
         if (clr) begin
            m_count = m_det ? 1 : 0;
            m_ovf   = m_drop;
         end else begin
            m_count = (m_count + (m_det ? 1 : 0)) % 256;
            m_ovf   = m_ovf | m_drop;
         end
      end
   end

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin
      chk("spike", spike, m_spike);
      chk("spike_count", spike_count, m_count);
      chk("overflow", overflow, m_ovf);
      chk("isi_valid", isi_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("isi_data", isi_data, m_q[0]);
   end

   task automatic drive(input logic [7:0] v, input logic e, input logic r, input logic c);
      v_in = v; ena = e; isi_ready = r; clr = c;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      v_in = 8'h00; ena = 1'b0; isi_ready = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
   endtask

   int  got[$];
   bit  seen;
   logic [7:0] v;

   initial begin
      #1 rst_n = 1'b0;
      do_reset();
      chk("reset_count", spike_count, 0);
      chk("reset_valid", isi_valid, 0);

      // Sub-threshold input never spikes
      thresh = 8'h10;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         drive(8'hD0, 1, 1, 0);
         seen |= spike;
      end
      chk("subthr_spike", seen, 0);
      chk("subthr_count", spike_count, 0);
      chk("subthr_valid", isi_valid, 0);

      // Periodic spikes every 10 enabled cycles, consumer always ready
      do_reset();
      got.delete();
      for (int i = 0; i < 60; i++) begin
         drive((i % 10 == 9) ? 8'h20 : 8'h00, 1, 1, 0);
         if (isi_valid) got.push_back(int'(isi_data));
      end
      chk("periodic_n", got.size(), 6);
      foreach (got[k]) chk("periodic_isi", got[k], 10);
      chk("periodic_count", spike_count, 6);

      // Five spikes into a depth-4 FIFO with no consumer: ISIs 3,5,7,4 kept, 6 dropped
      do_reset();
      for (int i = 0; i < 25; i++) begin
         drive((i == 2 || i == 7 || i == 14 || i == 18 || i == 24) ? 8'h20 : 8'h00, 1, 0, 0);
         if (i == 23) chk("ovf_before5", overflow, 0);
      end
      chk("ovf_after5", overflow, 1);
      chk("model_ovf", m_ovf, 1);
      chk("model_qsize", m_q.size(), 4);
      chk("ovf_count", spike_count, 5);
      got = '{3, 5, 7, 4};
      foreach (got[k]) begin
         chk("drain_isi", isi_data, got[k]);
         drive(8'h00, 1, 1, 0);
      end
      chk("drain_empty", isi_valid, 0);
      drive(8'h00, 1, 0, 1);
      chk("clr_ovf", overflow, 0);
      chk("clr_count", spike_count, 0);

      // Full FIFO: push coinciding with pop keeps overflow clear
      do_reset();
      for (int i = 0; i < 20; i++)
         drive((i == 1 || i == 4 || i == 8 || i == 13 || i == 19) ? 8'h20 : 8'h00, 1, i == 19, 0);
      chk("fullpop_ovf", overflow, 0);
      chk("fullpop_count", spike_count, 5);
      got = '{3, 4, 5, 6};
      foreach (got[k]) begin
         chk("fullpop_isi", isi_data, got[k]);
         drive(8'h00, 1, 1, 0);
      end
      chk("fullpop_empty", isi_valid, 0);

      // Asynchronous reset between edges with entries queued and a spike pending
      do_reset();
      for (int i = 0; i < 6; i++)
         drive((i == 1 || i == 3 || i == 5) ? 8'h20 : 8'h00, 1, 0, 0);
      chk("pre_arst_spike", spike, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_spike", spike, 0);
      chk("arst_count", spike_count, 0);
      chk("arst_valid", isi_valid, 0);
      chk("arst_ovf", overflow, 0);
      #4 rst_n = 1'b1;
      drive(8'h00, 1, 1, 0);
      chk("post_arst_valid", isi_valid, 0);
      chk("post_arst_count", spike_count, 0);

`ifdef SPIKE_MON_REFRACT_EN
      // Crossings 2 then 5 enabled cycles apart: second is locked out
      do_reset();
      for (int i = 0; i < 10; i++)
         drive((i == 1 || i == 3 || i == 8) ? 8'h20 : 8'h00, 1, 0, 0);
      chk("refr_count", spike_count, 2);
      chk("refr_isi0", isi_data, 2);
      drive(8'h00, 1, 1, 0);
      chk("refr_isi1", isi_data, 7);
`endif

      // Random traffic: enable gaps, backpressure, clears
      do_reset();
      thresh = 8'($urandom_range(0, 64)) - 8'd32;
      for (int i = 0; i < 3000; i++) begin
         v = 8'($urandom_range(0, 255));
         drive(v, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
